// File: rtl/button_pulse_conditioner.sv
// Raw push-button to clean one-cycle pulse: 2-flop synchronizer, debounce FSM, one-shot.
// Optional auto-repeat while held is enabled by defining BUTTON_PULSE_AUTO_REPEAT_EN.
module button_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    output logic pulse,
    output logic button_level
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)
        || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("button_pulse_conditioner: illegal parameter set");
    end

`ifdef BUTTON_PULSE_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    if ((64'd1 << CNT_W) <= 64'(REPEAT_DELAY) || (64'd1 << CNT_W) <= 64'(REPEAT_PERIOD)) begin : g_bad_rpt
        $error("button_pulse_conditioner: CNT_W too small for repeat timing");
    end

    logic repeating_r;
    logic repeating_s;
`endif

    logic [1:0]       sync_r;
    logic             btn_s;
    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             pulse_r;
    logic             pulse_s;
    logic             level_r;
    logic             level_s;

    assign btn_s        = sync_r[1];
    assign pulse        = pulse_r;
    assign button_level = level_r;

    // Two-flop synchronizer for the asynchronous button input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], button_in};
        end
    end

    // Debounce state, stable-time counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            pulse_r     <= 1'b0;
            level_r     <= 1'b0;
`ifdef BUTTON_PULSE_AUTO_REPEAT_EN
            repeating_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            pulse_r     <= pulse_s;
            level_r     <= level_s;
`ifdef BUTTON_PULSE_AUTO_REPEAT_EN
            repeating_r <= repeating_s;
`endif
        end
    end

    // Next-state, counter and strobe decode; counter is cleared on every state change
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        pulse_s     = 1'b0;
        level_s     = level_r;
`ifdef BUTTON_PULSE_AUTO_REPEAT_EN
        repeating_s = repeating_r;
`endif
        case (state_r)
            IDLE: begin
                if (btn_s) begin
                    state_s = PRESS_WAIT;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == DB_LAST) begin
                    state_s = PRESSED;
                    cnt_s   = CNT_ZERO;
                    pulse_s = 1'b1;
                    level_s = 1'b1;
`ifdef BUTTON_PULSE_AUTO_REPEAT_EN
                    repeating_s = 1'b0;
`endif
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_s = RELEASE_WAIT;
                    cnt_s   = CNT_ZERO;
`ifdef BUTTON_PULSE_AUTO_REPEAT_EN
                    repeating_s = 1'b0;
`endif
                end else begin
`ifdef BUTTON_PULSE_AUTO_REPEAT_EN
                    // First repeat after the long delay, then at the shorter period
                    if ((!repeating_r && cnt_r == RD_LAST) || (repeating_r && cnt_r == RP_LAST)) begin
                        pulse_s     = 1'b1;
                        cnt_s       = CNT_ZERO;
                        repeating_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
`else
                    cnt_s = CNT_ZERO;
`endif
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_s = PRESSED;
                    cnt_s   = CNT_ZERO;
`ifdef BUTTON_PULSE_AUTO_REPEAT_EN
                    repeating_s = 1'b0;
`endif
                end else if (cnt_r == DB_LAST) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                    level_s = 1'b0;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
                level_s = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Self-checking bench for button_pulse_conditioner: expected pulse cycles are queued when
// stimulus is driven and matched by a monitor whenever pulse is seen high.
module tb_button_pulse_conditioner;

    localparam int DB  = 4;
    localparam int LAT = DB + 3;   // negedge of drive to negedge after the pulse edge

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic button_in = 1'b0;
    logic pulse;
    logic button_level;

    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   q[$];
    bit   mon_en = 1'b0;

    button_pulse_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(8),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .button_in(button_in),
        .pulse(pulse),
        .button_level(button_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every pulse must match the oldest queued cycle; stale entries are misses
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0] < cyc) begin
                total++;
                $display("FAIL missed_pulse: pulse absent, required at cycle %0d (now %0d)", q[0], cyc);
                void'(q.pop_front());
            end
            if (pulse === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_pulse: pulse at cycle %0d, required none", cyc);
                end else begin
                    if (q[0] !== cyc) $display("FAIL pulse_time: got cycle %0d, required %0d", cyc, q[0]);
                    else passed++;
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic test_reset();
        button_in = 1'b0;
        reset = 1'b0;
        #125;
        total++; if (pulse !== 1'b0) $display("FAIL reset_pulse: got %b required 0", pulse); else passed++;
        total++; if (button_level !== 1'b0) $display("FAIL reset_level: got %b required 0", button_level); else passed++;
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_press();
        @(negedge clk);
        button_in = 1'b1;
        q.push_back(cyc + LAT);
        repeat (LAT - 1) @(negedge clk);
        total++; if (button_level !== 1'b0) $display("FAIL press_level_early: got %b required 0", button_level); else passed++;
        @(negedge clk);
        total++; if (button_level !== 1'b1) $display("FAIL press_level: got %b required 1", button_level); else passed++;
        repeat (5) @(negedge clk);
        total++; if (button_level !== 1'b1) $display("FAIL press_level_hold: got %b required 1", button_level); else passed++;
    endtask

    task automatic test_release_bounce();
        for (int d = 0; d < 2; d++) begin
            @(negedge clk); button_in = 1'b0;
            @(negedge clk); button_in = 1'b1;
            repeat (3) @(negedge clk);
            total++; if (button_level !== 1'b1) $display("FAIL dip_level[%0d]: got %b required 1", d, button_level); else passed++;
        end
        @(negedge clk);
        button_in = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        total++; if (button_level !== 1'b1) $display("FAIL release_level_early: got %b required 1", button_level); else passed++;
        @(negedge clk);
        total++; if (button_level !== 1'b0) $display("FAIL release_level: got %b required 0", button_level); else passed++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_bounce();
        int errs = 0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            button_in = (t % 2 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (button_level !== 1'b0) errs++;
        end
        total++; if (errs != 0) $display("FAIL bounce_level: %0d cycles high, required 0", errs); else passed++;
        @(negedge clk);
        button_in = 1'b1;
        q.push_back(cyc + LAT);
        repeat (LAT) @(negedge clk);
        total++; if (button_level !== 1'b1) $display("FAIL bounce_press_level: got %b required 1", button_level); else passed++;
        button_in = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        total++; if (button_level !== 1'b0) $display("FAIL bounce_release_level: got %b required 0", button_level); else passed++;
    endtask

    task automatic test_glitch();
        int errs = 0;
        @(negedge clk);
        button_in = 1'b1;
        repeat (3) @(negedge clk);
        button_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (button_level !== 1'b0) errs++;
        end
        total++; if (errs != 0) $display("FAIL glitch_level: %0d cycles high, required 0", errs); else passed++;
        // A full press right after must see the normal latency from IDLE
        button_in = 1'b1;
        q.push_back(cyc + LAT);
        repeat (LAT) @(negedge clk);
        total++; if (button_level !== 1'b1) $display("FAIL post_glitch_level: got %b required 1", button_level); else passed++;
        button_in = 1'b0;
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        button_in = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (pulse !== 1'b0 || button_level !== 1'b0)
            $display("FAIL mid_reset_outputs: got %b%b required 00", pulse, button_level); else passed++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        q.push_back(cyc + LAT);
        repeat (LAT - 1) @(negedge clk);
        total++; if (button_level !== 1'b0) $display("FAIL mid_reset_level_early: got %b required 0", button_level); else passed++;
        @(negedge clk);
        total++; if (button_level !== 1'b1) $display("FAIL mid_reset_level: got %b required 1", button_level); else passed++;
        button_in = 1'b0;
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic test_repeat();
        int p;
        @(negedge clk);
        button_in = 1'b1;
        p = cyc + LAT;
        q.push_back(p);
`ifdef BUTTON_PULSE_AUTO_REPEAT_EN
        for (int r = 20; r <= 60; r += 10) q.push_back(p + r);
`endif
        repeat (LAT + 61) @(negedge clk);
        total++; if (button_level !== 1'b1) $display("FAIL hold_level: got %b required 1", button_level); else passed++;
        button_in = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        total++; if (button_level !== 1'b0) $display("FAIL hold_release_level: got %b required 0", button_level); else passed++;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_press();
        test_release_bounce();
        test_bounce();
        test_glitch();
        test_reset_mid();
        test_repeat();
        for (int w = 0; w < 20 && q.size() > 0; w++) @(negedge clk);
        total++; if (q.size() != 0) $display("FAIL pending_pulses: got %0d outstanding, required 0", q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
